fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter AW, default 16, meaning PC and instruction-memory address width.
REQ-002 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for imem_ack before abort.
REQ-003 The module SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The module SHALL have port rst_f, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port ir_load, input, 1 bit: start a fetch from the current PC.
REQ-006 The module SHALL have port pc_write, input, 1 bit: update the PC this cycle.
REQ-007 The module SHALL have port pc_sel, input, 1 bit: 0 selects PC+1, 1 selects the branch target.
REQ-008 The module SHALL have port br_sel, input, 1 bit: 0 selects a relative target, 1 selects an absolute target.
REQ-009 The module SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-010 The module SHALL have port imem_addr, output, AW bits: read address, held stable while imem_req=1.
REQ-011 The module SHALL have port imem_rdata, input, 32 bits: read data, valid when imem_ack=1.
REQ-012 The module SHALL have port imem_ack, input, 1 bit: read complete.
REQ-013 The module SHALL have port opcode, output, 4 bits: IR[31:28].
REQ-014 The module SHALL have port mm, output, 4 bits: IR[27:24].
REQ-015 The module SHALL have port rd, rs, rt outputs, 4 bits each: IR[23:20], IR[19:16], IR[15:12].
REQ-016 The module SHALL have port imm, output, 16 bits: IR[15:0].
REQ-017 The module SHALL have port pc_out, output, AW bits: current PC.
REQ-018 The module SHALL have port ir_valid, output, 1 bit: the IR holds a completed fetch.
REQ-019 The module SHALL have port fetch_busy, output, 1 bit: a fetch is in progress.
REQ-020 The module SHALL have port fetch_err, output, 1 bit: sticky flag, set on timeout.

Function
REQ-021 The FSM SHALL have states IDLE, REQ and DONE; fetch_busy SHALL be 1 only in REQ.
REQ-022 IDLE with ir_load=1 SHALL go to REQ the next cycle, latching imem_addr=PC and clearing ir_valid and the wait counter.
REQ-023 In REQ, imem_req SHALL be 1 from the first REQ cycle until the cycle imem_ack=1 is sampled, inclusive, and 0 in all other states.
REQ-024 In REQ, imem_ack=1 SHALL load IR<=imem_rdata and go to DONE; ir_valid SHALL be 1 from the following cycle.
REQ-025 In REQ, the wait counter SHALL increment each cycle without ack; on reaching TIMEOUT with no ack, the unit SHALL load IR<=0 (NOOP), set fetch_err=1 and ir_valid=1, and go to DONE.
REQ-026 DONE SHALL go to IDLE unconditionally after one cycle; IR and ir_valid SHALL hold until the next ir_load.
REQ-027 ir_load asserted in REQ or DONE SHALL be ignored without queuing.
REQ-028 pc_write=1 with pc_sel=0 SHALL set PC<=PC+1, modulo 2^AW.
REQ-029 pc_write=1 with pc_sel=1 and br_sel=0 SHALL set PC<=PC+sign_extend(imm), modulo 2^AW.
REQ-030 pc_write=1 with pc_sel=1 and br_sel=1 SHALL set PC<=imm, zero-extended or truncated to AW.
REQ-031 pc_write SHALL be honoured in any state; a PC change during REQ SHALL NOT alter the latched imem_addr.
REQ-032 When ir_load and pc_write are both 1 in IDLE, the fetch SHALL use the pre-update PC.
REQ-033 imem_ack outside REQ SHALL be ignored.
REQ-034 Field outputs SHALL be combinational slices of the IR only, and SHALL change only when the IR is loaded.

Reset
REQ-035 rst_f=0 SHALL immediately force PC=0, IR=0, opcode=0, ir_valid=0, imem_req=0, fetch_busy=0, fetch_err=0, wait counter=0, state=IDLE.
REQ-036 A reset during REQ SHALL drop imem_req within the same cycle, and a late imem_ack SHALL be ignored.
REQ-037 fetch_err SHALL be cleared only by reset.

Verification
REQ-038 Reset, ir_load pulse, ack on the 3rd REQ cycle with rdata=0x81230005 -> imem_addr=0, imem_req high for 3 cycles, opcode=8, mm=1, rd=2, rs=3, imm=0x0005, ir_valid=1.
REQ-039 PC=0x0010, imm=0xFFFC, pc_write=1, pc_sel=1, br_sel=0 -> PC=0x000C; with br_sel=1 -> PC=0xFFFC.
REQ-040 PC=0xFFFF, pc_write=1, pc_sel=0 -> PC=0x0000.
REQ-041 ir_load with no ack -> imem_req high for exactly 15 cycles, then IR=0, fetch_err=1, ir_valid=1; a later successful fetch leaves fetch_err=1.
REQ-042 rst_f=0 mid-REQ, then ack -> imem_req=0 immediately, IR stays 0, ir_valid=0.
REQ-043 ir_load and pc_write(pc_sel=0) together at PC=5, then a second ir_load during REQ -> imem_addr=5, PC=6, one request only.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC and IR, and issues timed-out single-beat reads to instruction memory.
// The IR is decoded combinationally into its instruction fields.
module fetch_unit #(
   parameter int AW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          ir_load,
   input  logic          pc_write,
   input  logic          pc_sel,
   input  logic          br_sel,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          imem_ack,
   output logic [3:0]    opcode,
   output logic [3:0]    mm,
   output logic [3:0]    rd,
   output logic [3:0]    rs,
   output logic [3:0]    rt,
   output logic [15:0]   imm,
   output logic [AW-1:0] pc_out,
   output logic          ir_valid,
   output logic          fetch_busy,
   output logic          fetch_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   ir_q, ir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   logic [AW+15:0] imm_sext, imm_zext;

   assign imm_sext = {{AW{ir_q[15]}}, ir_q[15:0]};
   assign imm_zext = {{AW{1'b0}}, ir_q[15:0]};

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         addr_q  <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no latch can be inferred.
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      err_d   = err_q;

      if (pc_write) begin
         if (!pc_sel)     pc_d = pc_q + AW'(1);
         else if (!br_sel) pc_d = pc_q + imm_sext[AW-1:0];
         else             pc_d = imm_zext[AW-1:0];
      end

      unique case (state_q)
         S_IDLE: begin
            if (ir_load) begin
               state_d = S_REQ;
               addr_d  = pc_q;   // pre-update PC, even if pc_write is also set
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end
         S_REQ: begin
            if (imem_ack) begin
               state_d = S_DONE;
               ir_d    = imem_rdata;
               valid_d = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_DONE;
               ir_d    = '0;
               valid_d = 1'b1;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req   = (state_q == S_REQ);
   assign fetch_busy = (state_q == S_REQ);
   assign imem_addr  = addr_q;
   assign pc_out     = pc_q;
   assign ir_valid   = valid_q;
   assign fetch_err  = err_q;

   assign opcode = ir_q[31:28];
   assign mm     = ir_q[27:24];
   assign rd     = ir_q[23:20];
   assign rs     = ir_q[19:16];
   assign rt     = ir_q[15:12];
   assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random cycles against a behavioural model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_fetch_unit;

   localparam int AW      = 16;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst_f;
   logic          ir_load, pc_write, pc_sel, br_sel;
   logic          imem_req, imem_ack;
   logic [AW-1:0] imem_addr, pc_out;
   logic [31:0]   imem_rdata;
   logic [3:0]    opcode, mm, rd, rs, rt;
   logic [15:0]   imm;
   logic          ir_valid, fetch_busy, fetch_err;

   fetch_unit #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_f(rst_f), .ir_load(ir_load), .pc_write(pc_write),
      .pc_sel(pc_sel), .br_sel(br_sel), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .opcode(opcode), .mm(mm),
      .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out), .ir_valid(ir_valid),
      .fetch_busy(fetch_busy), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural model: fetch in progress is tracked as a count of elapsed wait cycles.
   logic [AW-1:0] m_pc, m_addr;
   logic [31:0]   m_ir;
   bit            m_valid, m_err, m_fetching, m_settling;
   int            m_waited;

   // Request bookkeeping observed at each sample point
   int req_cycles, req_rises;
   bit prev_req;

   task automatic model_reset();
      m_pc = '0; m_addr = '0; m_ir = '0;
      m_valid = 0; m_err = 0; m_fetching = 0; m_settling = 0; m_waited = 0;
      prev_req = 0;
   endtask

   task automatic model_edge();
      logic [AW-1:0] old_pc;
      old_pc = m_pc;
      if (pc_write) begin
         if (!pc_sel)      m_pc = AW'(int'(m_pc) + 1);
         else if (!br_sel) m_pc = AW'(int'(m_pc) + int'(signed'(m_ir[15:0])));
         else              m_pc = AW'(m_ir[15:0]);
      end
      if (m_fetching) begin
         if (imem_ack) begin
            m_ir = imem_rdata; m_valid = 1; m_fetching = 0; m_settling = 1;
         end else if (m_waited + 1 == TIMEOUT) begin
            m_ir = '0; m_valid = 1; m_err = 1; m_fetching = 0; m_settling = 1;
         end else begin
            m_waited++;
         end
      end else if (m_settling) begin
         m_settling = 0;
      end else if (ir_load) begin
         m_addr = old_pc; m_valid = 0; m_waited = 0; m_fetching = 1;
      end
   endtask

   task automatic compare_all();
      check("imem_req", 32'(imem_req), 32'(m_fetching));
      check("fetch_busy", 32'(fetch_busy), 32'(m_fetching));
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("ir_fields", {opcode, mm, rd, rs, imm}, m_ir);
      check("rt", 32'(rt), 32'(m_ir[15:12]));
      check("ir_valid", 32'(ir_valid), 32'(m_valid));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
      if (m_fetching) check("imem_addr", 32'(imem_addr), 32'(m_addr));
   endtask

   task automatic step(input bit ld, input bit pw, input bit ps, input bit bs,
                       input bit ack, input logic [31:0] rdat);
      ir_load = ld; pc_write = pw; pc_sel = ps; br_sel = bs;
      imem_ack = ack; imem_rdata = rdat;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (imem_req) req_cycles++;
      if (imem_req && !prev_req) req_rises++;
      prev_req = imem_req;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_f = 1'b0;
      #1;
      model_reset();
      check("rst_pc", 32'(pc_out), 32'h0);
      check("rst_opcode", 32'(opcode), 32'h0);
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_busy", 32'(fetch_busy), 32'h0);
      check("rst_valid", 32'(ir_valid), 32'h0);
      check("rst_err", 32'(fetch_err), 32'h0);
      @(negedge clk);
      rst_f = 1'b1;
   endtask

   // Fetch a word returned on the first REQ cycle
   task automatic fetch_word(input logic [31:0] w);
      step(1, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 1, w);
      idle(1);
   endtask

   initial begin
      rst_f = 1'b1; ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
      imem_ack = 0; imem_rdata = '0;
      model_reset();
      #2 rst_f = 1'b0;

      // Basic fetch, ack on the third REQ cycle
      do_reset();
      req_cycles = 0;
      step(1, 0, 0, 0, 0, 32'h0);
      check("addr_first", 32'(imem_addr), 32'h0);
      step(0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 1, 32'h8123_0005);
      check("req_cycles_ack3", 32'(req_cycles), 32'd3);
      check("opcode_8", 32'(opcode), 32'h8);
      check("mm_1", 32'(mm), 32'h1);
      check("rd_2", 32'(rd), 32'h2);
      check("rs_3", 32'(rs), 32'h3);
      check("imm_5", 32'(imm), 32'h0005);
      check("valid_after_ack", 32'(ir_valid), 32'h1);
      idle(3);

      // Branch targets: absolute to 0x10, relative -4, absolute 0xFFFC, then wrap
      fetch_word(32'h0000_0010);
      step(0, 1, 1, 1, 0, 32'h0);
      check("pc_abs_10", 32'(pc_out), 32'h0010);
      fetch_word(32'h1000_FFFC);
      step(0, 1, 1, 0, 0, 32'h0);
      check("pc_rel_0C", 32'(pc_out), 32'h000C);
      step(0, 1, 1, 1, 0, 32'h0);
      check("pc_abs_FFFC", 32'(pc_out), 32'hFFFC);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0);
      check("pc_FFFF", 32'(pc_out), 32'hFFFF);
      step(0, 1, 0, 0, 0, 32'h0);
      check("pc_wrap", 32'(pc_out), 32'h0000);

      // Timeout with no ack, then a good fetch keeps the sticky error
      req_cycles = 0;
      step(1, 0, 0, 0, 0, 32'h0);
      idle(TIMEOUT + 2);
      check("req_cycles_timeout", 32'(req_cycles), 32'(TIMEOUT));
      check("timeout_ir", {opcode, mm, rd, rs, imm}, 32'h0);
      check("timeout_err", 32'(fetch_err), 32'h1);
      check("timeout_valid", 32'(ir_valid), 32'h1);
      fetch_word(32'h4567_89AB);
      check("err_sticky", 32'(fetch_err), 32'h1);
      check("opcode_after_err", 32'(opcode), 32'h4);

      // Reset in the middle of REQ, then a late ack
      step(1, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 32'h0);
      rst_f = 1'b0;
      #1;
      model_reset();
      check("midreq_reset_req", 32'(imem_req), 32'h0);
      check("midreq_reset_busy", 32'(fetch_busy), 32'h0);
      @(negedge clk);
      rst_f = 1'b1;
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      check("late_ack_ir", {opcode, mm, rd, rs, imm}, 32'h0);
      check("late_ack_valid", 32'(ir_valid), 32'h0);

      // Simultaneous ir_load + pc_write at PC=5, second ir_load during REQ ignored
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 32'h0);
      req_rises = 0;
      step(1, 1, 0, 0, 0, 32'h0);
      check("simul_addr", 32'(imem_addr), 32'h5);
      check("simul_pc", 32'(pc_out), 32'h6);
      step(1, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 1, 32'hA000_0001);
      step(1, 0, 0, 0, 0, 32'h0);
      idle(4);
      check("one_request", 32'(req_rises), 32'd1);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0, $urandom);
         if ($urandom_range(0, 999) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
